// File: rtl/addsub_accumulator_if.sv
// addsub_accumulator_if: beat input and frame-total output bundle for addsub_accumulator.
//   in_valid/in_ready    : upstream beat handshake
//   in_result, in_cout   : adder/subtractor result and carry-out
//   in_mode0, in_mode1   : mode bits that produced the beat (01 add, 10 subtract)
//   out_valid/out_ready  : frame total handshake
//   out_acc              : signed frame total, ACC_W bits
//   out_ovf, out_err     : sticky overflow / illegal-mode flags for the frame
//   out_count            : beats accepted in the current frame
// master drives beats and out_ready; slave is the accumulator.
interface addsub_accumulator_if #(
    parameter int ACC_W = 16,
    parameter int N_OPS = 4
);
    localparam int CNT_W = $clog2(N_OPS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_result;
    logic             in_cout;
    logic             in_mode0;
    logic             in_mode1;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic             out_err;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_result, in_cout, in_mode0, in_mode1, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, out_err, out_count
    );

    modport slave (
        input  in_valid, in_result, in_cout, in_mode0, in_mode1, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, out_err, out_count
    );
endinterface

// File: rtl/addsub_accumulator.sv
// addsub_accumulator: accumulates N_OPS adder/subtractor result beats into a signed ACC_W-bit
// total and presents it with sticky overflow/error flags on a valid/ready port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous frame abort, same effect as reset, beats/handshakes that cycle dropped
//   bus   : addsub_accumulator_if slave (beat input, frame-total output)
module addsub_accumulator #(
    parameter int ACC_W = 16,
    parameter int N_OPS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    addsub_accumulator_if.slave   bus
);
    localparam int CNT_W = $clog2(N_OPS + 1);

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_DONE    = 1'b1;

    logic             state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] operand;
    logic [ACC_W-1:0] sum;
    logic             illegal;
    logic             ovf_now;
    logic             accept;

    // Beat to signed operand. Subtract results carry an inverted borrow in cout, so
    // {~cout, result} is the 9-bit two's complement difference.
    always_comb begin
        operand = '0;
        illegal = 1'b0;
        unique case ({bus.in_mode1, bus.in_mode0})
            2'b01:   operand = {{(ACC_W-9){1'b0}}, bus.in_cout, bus.in_result};
            2'b10:   operand = {{(ACC_W-9){~bus.in_cout}}, ~bus.in_cout, bus.in_result};
            default: illegal = 1'b1;
        endcase
    end

    assign sum     = acc_q + operand;
    // Signed overflow: operands agree in sign, result does not.
    assign ovf_now = (acc_q[ACC_W-1] == operand[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign accept  = (state_q == ST_COLLECT) && bus.in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (clear) begin
            state_d = ST_COLLECT;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            acc_d   = sum;
            count_d = count_q + CNT_W'(1);
            ovf_d   = ovf_q | ovf_now;
            err_d   = err_q | illegal;
            if (count_q == CNT_W'(N_OPS - 1)) begin
                state_d = ST_DONE;
            end
        end else if ((state_q == ST_DONE) && bus.out_ready) begin
            state_d = ST_COLLECT;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Outputs come straight from registers or the state decode only.
    assign bus.in_ready  = (state_q == ST_COLLECT);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_err   = err_q;
    assign bus.out_count = count_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator: a 16-bit instance for most frames and a 10-bit
// instance for the overflow frame.
module tb_addsub_accumulator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    addsub_accumulator_if #(.ACC_W(16), .N_OPS(4)) bus_a ();
    addsub_accumulator_if #(.ACC_W(10), .N_OPS(4)) bus_b ();

    addsub_accumulator #(.ACC_W(16), .N_OPS(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus_a.slave)
    );

    addsub_accumulator #(.ACC_W(10), .N_OPS(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus_b.slave)
    );

    localparam logic [1:0] M_ADD = 2'b01;
    localparam logic [1:0] M_SUB = 2'b10;
    localparam logic [1:0] M_00  = 2'b00;
    localparam logic [1:0] M_11  = 2'b11;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One beat on bus_a; returns #1 after the accepting edge.
    task automatic beat_a(input logic [1:0] mode, input logic [7:0] res, input logic cout);
        @(negedge clk);
        bus_a.in_valid  = 1'b1;
        bus_a.in_mode1  = mode[1];
        bus_a.in_mode0  = mode[0];
        bus_a.in_result = res;
        bus_a.in_cout   = cout;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic handshake_a();
        @(negedge clk);
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b0;
    endtask

    // {cout, result}
    logic [8:0] add_vec [4];
    logic [8:0] sub_vec [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        add_vec = '{9'h003, 9'h0C2, 9'h0E3, 9'h163};
        sub_vec = '{9'h101, 9'h17D, 9'h051, 9'h0D9};
        bus_a.in_valid = 1'b0; bus_a.in_result = '0; bus_a.in_cout = 1'b0;
        bus_a.in_mode0 = 1'b0; bus_a.in_mode1 = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_result = '0; bus_b.in_cout = 1'b0;
        bus_b.in_mode0 = 1'b0; bus_b.in_mode1 = 1'b0; bus_b.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_count", 32'(bus_a.out_count), 32'd0);
        check_eq("rst_acc", 32'(bus_a.out_acc), 32'd0);
        check_eq("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check_eq("rst_flags", 32'({bus_a.out_ovf, bus_a.out_err}), 32'd0);

        // Reset mid-frame after two beats
        beat_a(M_ADD, 8'h03, 1'b0);
        beat_a(M_ADD, 8'hC2, 1'b0);
        check_eq("mid_count", 32'(bus_a.out_count), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_count", 32'(bus_a.out_count), 32'd0);
        check_eq("mid_rst_acc", 32'(bus_a.out_acc), 32'd0);
        check_eq("mid_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        check_eq("mid_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Add frame: 3 + 194 + 227 + 355 = 779
        for (int i = 0; i < 4; i++) begin
            beat_a(M_ADD, add_vec[i][7:0], add_vec[i][8]);
            if (i < 3) begin
                check_eq("add_count", 32'(bus_a.out_count), 32'(i + 1));
                check_eq("add_no_valid", 32'(bus_a.out_valid), 32'd0);
            end
        end
        check_eq("add_valid", 32'(bus_a.out_valid), 32'd1);
        check_eq("add_in_ready", 32'(bus_a.in_ready), 32'd0);
        check_eq("add_acc", 32'(bus_a.out_acc), 32'h030B);
        check_eq("add_ovf", 32'(bus_a.out_ovf), 32'd0);
        check_eq("add_err", 32'(bus_a.out_err), 32'd0);
        check_eq("add_count4", 32'(bus_a.out_count), 32'd4);
        handshake_a();
        check_eq("add_hs_valid", 32'(bus_a.out_valid), 32'd0);
        check_eq("add_hs_in_ready", 32'(bus_a.in_ready), 32'd1);
        check_eq("add_hs_count", 32'(bus_a.out_count), 32'd0);
        check_eq("add_hs_acc", 32'(bus_a.out_acc), 32'd0);

        // Subtract frame: 1 + 125 - 175 - 39 = -88
        for (int i = 0; i < 4; i++) begin
            beat_a(M_SUB, sub_vec[i][7:0], sub_vec[i][8]);
        end
        check_eq("sub_valid", 32'(bus_a.out_valid), 32'd1);
        check_eq("sub_acc", 32'(bus_a.out_acc), 32'hFFA8);
        check_eq("sub_ovf", 32'(bus_a.out_ovf), 32'd0);
        handshake_a();

        // Overflow on the 10-bit instance: 510 x4 wraps to 0x3F8
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_b.in_valid  = 1'b1;
            bus_b.in_mode1  = 1'b0;
            bus_b.in_mode0  = 1'b1;
            bus_b.in_result = 8'hFE;
            bus_b.in_cout   = 1'b1;
            @(posedge clk);
            #1;
            bus_b.in_valid = 1'b0;
        end
        check_eq("ovf_valid", 32'(bus_b.out_valid), 32'd1);
        check_eq("ovf_acc", 32'(bus_b.out_acc), 32'h3F8);
        check_eq("ovf_flag", 32'(bus_b.out_ovf), 32'd1);
        @(negedge clk);
        bus_b.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_b.out_ready = 1'b0;
        check_eq("ovf_hs_flag", 32'(bus_b.out_ovf), 32'd0);

        // Illegal modes, then backpressure with a beat offered during DONE
        beat_a(M_ADD, 8'h03, 1'b0);
        beat_a(M_11, 8'h55, 1'b1);
        beat_a(M_00, 8'hAA, 1'b0);
        beat_a(M_SUB, 8'h01, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_a.in_valid  = 1'b1;
            bus_a.in_mode1  = 1'b0;
            bus_a.in_mode0  = 1'b1;
            bus_a.in_result = 8'h10;
            bus_a.in_cout   = 1'b0;
            @(posedge clk);
            #1;
            check_eq("bp_acc", 32'(bus_a.out_acc), 32'd4);
            check_eq("bp_err", 32'(bus_a.out_err), 32'd1);
            check_eq("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
            check_eq("bp_valid", 32'(bus_a.out_valid), 32'd1);
            check_eq("bp_count", 32'(bus_a.out_count), 32'd4);
        end
        bus_a.in_valid = 1'b0;
        handshake_a();
        check_eq("bp_hs_valid", 32'(bus_a.out_valid), 32'd0);
        check_eq("bp_hs_in_ready", 32'(bus_a.in_ready), 32'd1);
        check_eq("bp_hs_count", 32'(bus_a.out_count), 32'd0);
        check_eq("bp_hs_err", 32'(bus_a.out_err), 32'd0);
        check_eq("bp_hs_acc", 32'(bus_a.out_acc), 32'd0);

        // Clear on the 3rd beat drops it and the partial frame
        beat_a(M_ADD, 8'h03, 1'b0);
        beat_a(M_ADD, 8'hC2, 1'b0);
        @(negedge clk);
        bus_a.in_valid  = 1'b1;
        bus_a.in_mode1  = 1'b0;
        bus_a.in_mode0  = 1'b1;
        bus_a.in_result = 8'hE3;
        bus_a.in_cout   = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        clear = 1'b0;
        check_eq("clr_count", 32'(bus_a.out_count), 32'd0);
        check_eq("clr_acc", 32'(bus_a.out_acc), 32'd0);
        check_eq("clr_valid", 32'(bus_a.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat_a(M_ADD, add_vec[i][7:0], add_vec[i][8]);
        end
        check_eq("clr_frame_valid", 32'(bus_a.out_valid), 32'd1);
        check_eq("clr_frame_acc", 32'(bus_a.out_acc), 32'h030B);
        check_eq("clr_frame_count", 32'(bus_a.out_count), 32'd4);
        handshake_a();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/addsub_accumulator.md
# addsub_accumulator

Downstream consumer for the 8-bit controlled adder/subtractor. Accepts one result beat per handshake: the 8-bit result, carry-out and the two mode bits that produced it. It converts each beat to a signed operand and accumulates N_OPS beats into an ACC_W-bit signed total. It then presents the frame total, with sticky overflow and error flags, on a valid/ready output port.

## Interface
- ACC_W, 16, accumulator width in bits, signed two's complement; legal range is 10 or more.
- N_OPS, 4, number of accepted beats per frame; legal range is 1 or more.
- CNT_W, $clog2(N_OPS+1), width of the beat counter (derived parameter).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low. Asserts immediately; release is synchronous to clk.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_result  input  8  adder/subtractor result.
- in_cout  input  1  adder/subtractor carry-out.
- in_mode0  input  1  add select.
- in_mode1  input  1  subtract select.
- out_valid  output  1  frame total valid.
- out_ready  input  1  downstream accepts the total.
- out_acc  output  ACC_W  accumulated signed total.
- out_ovf  output  1  sticky signed overflow within the frame.
- out_err  output  1  sticky illegal-mode beat seen within the frame.
- out_count  output  CNT_W  beats accepted in the current frame.

## Operation
- The FSM has two states, COLLECT and DONE. Reset and clear both force COLLECT.
- Beat conversion to a signed operand v:
  - Add (mode1=0, mode0=1): v = zero-extended {in_cout, in_result}. Range is 0 to 511.
  - Subtract (mode1=1, mode0=0): v = sign-extended 9-bit {~in_cout, in_result}. Range is -256 to 255. cout=1 means no borrow.
  - Illegal (modes 00 or 11): v = 0, and out_err is set. The beat is still consumed and still counted.
- COLLECT state:
  - in_ready = 1.
  - Each accepted beat (in_valid && in_ready) updates acc <= acc + v, wrapping modulo 2^ACC_W. It also increments out_count.
  - out_ovf is set when the operands of acc + v have equal signs and the sum's sign differs from them.
- COLLECT to DONE: on the beat that makes out_count equal N_OPS.
- DONE state:
  - in_ready = 0 and out_valid = 1.
  - out_acc, out_ovf, out_err and out_count are held stable.
  - While out_ready = 0, all outputs hold indefinitely.
- DONE to COLLECT: on out_valid && out_ready. The same edge clears acc, out_count, out_ovf and out_err.
- clear = 1 at a clock edge has the same effect as reset:
  - It applies in any state, and a beat or output handshake in that cycle is discarded.
  - Priority order is rst_n, then clear, then handshakes.

## Timing
- Reset values: acc = 0, out_acc = 0, out_count = 0, out_ovf = 0, out_err = 0, out_valid = 0, in_ready = 1, state = COLLECT.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Latency: out_valid rises on the clock edge that accepts beat N_OPS. The total is visible in the cycle immediately after the last beat is presented.
- Back-to-back input: one beat per cycle is accepted with no bubbles inside a frame.
- Frame turnaround:
  - in_ready rises the cycle after the output handshake.
  - There is no same-cycle input acceptance in DONE.
  - The minimum frame period is N_OPS + 1 cycles.
- When N_OPS = 1, every accepted beat produces a frame.
- Simultaneous events:
  - Illegal mode with overflow cannot occur, because v = 0.
  - The overflow flag is evaluated on the final beat before the transition to DONE.
- Reset mid-frame drops the partial accumulation. out_valid deasserts asynchronously.

## Test plan
- Reset: assert rst_n=0 mid-frame after 2 beats, then release. Required: out_count=0, out_acc=0, in_ready=1, out_valid=0, with no frame emitted.
- Add frame (ACC_W=16, N_OPS=4). Beats:
  - result 0x03, cout 0
  - result 0xC2, cout 0
  - result 0xE3, cout 0
  - result 0x63, cout 1
  - Required: out_acc=0x030B (779), out_ovf=0, out_err=0, out_count=4, out_valid 1 cycle after the 4th beat.
- Subtract frame. Beats (mode1=1, mode0=0):
  - result 0x01, cout 1
  - result 0x7D, cout 1
  - result 0x51, cout 0
  - result 0xD9, cout 0
  - Required: out_acc=0xFFA8 (-88), out_ovf=0.
- Overflow (ACC_W=10). Four add beats of result 0xFE, cout 1 (510 each). Required: out_acc=0x3F8, out_ovf=1.
- Illegal mode and backpressure:
  - Send the beats add 0x03 cout 0, mode 11, mode 00, then subtract 0x01 cout 1.
  - Hold out_ready=0 for 5 cycles.
  - Required: out_acc=4 and out_err=1, held for all 5 cycles; in_ready=0 throughout; a beat offered during DONE is not consumed.
  - After out_ready=1, required: counters and flags clear and in_ready=1 on the next cycle.
- Clear: assert clear in the same cycle as a valid 3rd beat. Required: the beat is discarded and out_count=0. A following 4-beat frame totals correctly.
